// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge
// Purpose  : Host-side TX/RX byte FIFOs in front of a simple UART, with a
//            4-state launch sequencer, RX overflow flag and error counter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  output logic          tx_ready,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic          uart_transmit,
  output logic [7:0]    uart_tx_byte,
  input  logic          uart_is_transmitting,
  input  logic          uart_received,
  input  logic [7:0]    uart_rx_byte,
  input  logic          uart_recv_error,
  input  logic          clear,
  output logic [AW:0]   tx_count,
  output logic [AW:0]   rx_count,
  output logic          rx_overflow,
  output logic [7:0]    rx_err_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // Reset: asserts asynchronously, releases two edges after rst_n rises so
  // every flop below leaves reset on the same clk edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  // Synchroniser shift value.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Synchroniser register, cleared directly by the external reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------- TX side
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW:0]   tx_count_q, tx_count_d;
  logic          tx_push, tx_pop;
  tx_state_t     tx_state_q, tx_state_d;
  logic [7:0]    uart_tx_byte_q, uart_tx_byte_d;

  assign tx_ready = (tx_count_q != FULL_COUNT);
  assign tx_push  = tx_valid && tx_ready;

  // Launch sequencer: pop one byte, pulse start, then follow the UART busy line.
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_pop         = 1'b0;
    uart_tx_byte_d = uart_tx_byte_q;
    case (tx_state_q)
      ST_IDLE: begin
        if ((tx_count_q != '0) && !uart_is_transmitting) begin
          tx_pop         = 1'b1;
          uart_tx_byte_d = tx_mem[tx_rd_ptr_q];
          tx_state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH:    tx_state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (uart_is_transmitting)  tx_state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!uart_is_transmitting) tx_state_d = ST_IDLE;
      default:      tx_state_d = ST_IDLE;
    endcase
  end

  // TX pointer and occupancy update; simultaneous push and pop leave the count alone.
  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + AW'(1) : tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push && !tx_pop)      tx_count_d = tx_count_q + (AW+1)'(1);
    else if (tx_pop && !tx_push) tx_count_d = tx_count_q - (AW+1)'(1);
  end

  // TX storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_data;
  end

  assign uart_transmit = (tx_state_q == ST_LAUNCH);
  assign uart_tx_byte  = uart_tx_byte_q;
  assign tx_count      = tx_count_q;

  // ---------------------------------------------------------------- RX side
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW:0]   rx_count_q, rx_count_d;
  logic          rx_full, rx_push, rx_pop, rx_drop;
  logic          rx_overflow_q, rx_overflow_d;
  logic [7:0]    rx_err_count_q, rx_err_count_d;

  assign rx_full  = (rx_count_q == FULL_COUNT);
  assign rx_valid = (rx_count_q != '0);
  assign rx_pop   = rx_ready && rx_valid;
  // A full FIFO still accepts a byte when the host frees a slot on the same edge.
  assign rx_push  = uart_received && (!rx_full || rx_pop);
  assign rx_drop  = uart_received && rx_full && !rx_pop;

  // RX pointer and occupancy update.
  always_comb begin
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + AW'(1) : rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + (AW+1)'(1);
    else if (rx_pop && !rx_push) rx_count_d = rx_count_q - (AW+1)'(1);
  end

  // Status flags: clear takes effect first so a same-cycle event still lands.
  always_comb begin
    rx_overflow_d = rx_overflow_q;
    if (clear)   rx_overflow_d = 1'b0;
    if (rx_drop) rx_overflow_d = 1'b1;
    rx_err_count_d = clear ? 8'd0 : rx_err_count_q;
    if (uart_recv_error && (rx_err_count_d != 8'hFF))
      rx_err_count_d = rx_err_count_d + 8'd1;
  end

  // RX storage.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= uart_rx_byte;
  end

  assign rx_data      = rx_mem[rx_rd_ptr_q];
  assign rx_count     = rx_count_q;
  assign rx_overflow  = rx_overflow_q;
  assign rx_err_count = rx_err_count_q;

  // All control state, reset from the synchronised reset.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tx_state_q     <= ST_IDLE;
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      tx_count_q     <= '0;
      uart_tx_byte_q <= 8'h00;
      rx_wr_ptr_q    <= '0;
      rx_rd_ptr_q    <= '0;
      rx_count_q     <= '0;
      rx_overflow_q  <= 1'b0;
      rx_err_count_q <= 8'h00;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_wr_ptr_q    <= tx_wr_ptr_d;
      tx_rd_ptr_q    <= tx_rd_ptr_d;
      tx_count_q     <= tx_count_d;
      uart_tx_byte_q <= uart_tx_byte_d;
      rx_wr_ptr_q    <= rx_wr_ptr_d;
      rx_rd_ptr_q    <= rx_rd_ptr_d;
      rx_count_q     <= rx_count_d;
      rx_overflow_q  <= rx_overflow_d;
      rx_err_count_q <= rx_err_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_bridge
// Purpose  : Scoreboard bench for uart_fifo_bridge with a small UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BUSY_CYCLES = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tx_valid = 1'b0, rx_ready = 1'b0, uart_received = 1'b0;
  logic uart_recv_error = 1'b0, clear = 1'b0;
  logic [7:0] tx_data = 8'h00, uart_rx_byte = 8'h00;
  logic tx_ready, rx_valid, uart_transmit, uart_is_transmitting, rx_overflow;
  logic [7:0] rx_data, uart_tx_byte, rx_err_count;
  logic [AW:0] tx_count, rx_count;

  logic model_busy = 1'b0, hold_busy = 1'b0, abandon = 1'b0;
  assign uart_is_transmitting = model_busy | hold_busy;

  int n_cmp = 0, n_fail = 0, cyc = 0, pulse_cnt = 0, last_wr_cyc = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  uart_fifo_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received(uart_received), .uart_rx_byte(uart_rx_byte),
    .uart_recv_error(uart_recv_error), .clear(clear),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .rx_err_count(rx_err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // TX monitor: every start pulse pops the scoreboard.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_transmit) begin
        pulse_cnt++;
        check("tx_no_back_to_back", {31'd0, prev}, 32'd0);
        if (exp_tx.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected_pulse: got byte 0x%0h, expected no pulse", uart_tx_byte);
        end else begin
          check("tx_byte", {24'd0, uart_tx_byte}, {24'd0, exp_tx.pop_front()});
        end
      end
      prev = uart_transmit;
    end
  end

  // UART model: busy for a few cycles after each start pulse; byte must hold.
  initial begin
    logic [7:0] launched;
    forever begin
      @(negedge clk);
      if (uart_transmit) begin
        launched = uart_tx_byte;
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (BUSY_CYCLES - 1) @(posedge clk);
        @(negedge clk);
        if (!abandon) check("tx_byte_held", {24'd0, uart_tx_byte}, {24'd0, launched});
        @(posedge clk); #1 model_busy = 1'b0;
      end
    end
  end

  // RX monitor: every host pop is compared with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rx_unexpected_pop: got 0x%0h, expected none", rx_data);
        end else begin
          check("rx_byte", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic tx_write(input logic [7:0] d);
    int k = 0;
    tx_valid = 1'b1; tx_data = d; exp_tx.push_back(d);
    do begin @(negedge clk); k++; end while (!tx_ready && k < 200);
    if (k >= 200) begin n_cmp++; n_fail++; $display("FAIL tx_write_timeout: got tx_ready=0, expected 1"); end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic rx_recv(input logic [7:0] d);
    uart_received = 1'b1; uart_rx_byte = d;
    @(posedge clk); #1 uart_received = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int k = 0;
    while ((exp_tx.size() != 0 || uart_is_transmitting) && k < 1000) begin
      @(negedge clk); k++;
    end
    check("tx_drain_in_time", {31'd0, (k < 1000)}, 32'd1);
    repeat (BUSY_CYCLES + 4) @(posedge clk);
    #1;
    check("tx_count_drained", {27'd0, tx_count}, 32'd0);
  endtask

  initial begin
    int k;
    int pulses_before;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_uart_transmit", {31'd0, uart_transmit}, 32'd0);
    check("rst_uart_tx_byte", {24'd0, uart_tx_byte}, 32'h00);
    check("rst_tx_count", {27'd0, tx_count}, 32'd0);
    check("rst_rx_count", {27'd0, rx_count}, 32'd0);
    check("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
    check("rst_rx_err_count", {24'd0, rx_err_count}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single byte with idle UART: pulse in the cycle after the following edge.
    tx_write(8'hA5);
    k = 0;
    while (!uart_transmit && k < 20) begin @(negedge clk); k++; end
    check("tx_pulse_seen", {31'd0, uart_transmit}, 32'd1);
    check("tx_latency_edges", cyc - last_wr_cyc, 32'd1);
    @(posedge clk); #1;
    wait_tx_idle();

    // Fill TX FIFO behind a busy UART, then release it.
    hold_busy = 1'b1;
    for (int i = 1; i <= 16; i++) tx_write(8'(i));
    @(negedge clk);
    check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    check("tx_count_full", {27'd0, tx_count}, 32'd16);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hEE;
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    check("tx_push_full_ignored", {27'd0, tx_count}, 32'd16);
    @(posedge clk); #1 hold_busy = 1'b0;
    wait_tx_idle();

    // Write and pop on the same edge.
    hold_busy = 1'b1;
    tx_write(8'h5A);
    hold_busy = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3; exp_tx.push_back(8'hC3);
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    check("tx_count_push_pop", {27'd0, tx_count}, 32'd1);
    @(posedge clk); #1;
    wait_tx_idle();

    // RX overflow: 17 bytes with host stalled.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_rx.push_back(8'h30 + 8'(i));
      rx_recv(8'h30 + 8'(i));
    end
    @(negedge clk);
    check("rx_count_full", {27'd0, rx_count}, 32'd16);
    check("rx_overflow_set", {31'd0, rx_overflow}, 32'd1);
    check("rx_head", {24'd0, rx_data}, 32'h30);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check("rx_overflow_cleared", {31'd0, rx_overflow}, 32'd0);
    check("rx_count_after_clear", {27'd0, rx_count}, 32'd16);

    // Full RX FIFO with receive and pop on the same edge.
    @(posedge clk); #1;
    uart_received = 1'b1; uart_rx_byte = 8'h99; rx_ready = 1'b1; exp_rx.push_back(8'h99);
    @(posedge clk); #1 uart_received = 1'b0; rx_ready = 1'b0;
    @(negedge clk);
    check("rx_count_full_pop_push", {27'd0, rx_count}, 32'd16);
    check("rx_overflow_not_set", {31'd0, rx_overflow}, 32'd0);
    @(posedge clk); #1 rx_ready = 1'b1;
    k = 0;
    while (rx_valid && k < 100) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    check("rx_scoreboard_empty", exp_rx.size(), 32'd0);
    check("rx_count_drained", {27'd0, rx_count}, 32'd0);
    check("rx_valid_drained", {31'd0, rx_valid}, 32'd0);

    // Error counter saturation, then clear colliding with an error.
    @(posedge clk); #1 uart_recv_error = 1'b1;
    repeat (300) @(posedge clk);
    #1 uart_recv_error = 1'b0;
    @(negedge clk);
    check("err_count_saturated", {24'd0, rx_err_count}, 32'd255);
    @(posedge clk); #1 clear = 1'b1; uart_recv_error = 1'b1;
    @(posedge clk); #1 clear = 1'b0; uart_recv_error = 1'b0;
    @(negedge clk);
    check("err_count_clear_vs_error", {24'd0, rx_err_count}, 32'd1);

    // Reset during WAIT_DONE with five bytes queued.
    @(posedge clk); #1 abandon = 1'b1;
    for (int i = 0; i < 6; i++) tx_write(8'h70 + 8'(i));
    @(negedge clk);
    check("tx_count_before_reset", {27'd0, tx_count}, 32'd5);
    check("uart_busy_before_reset", {31'd0, uart_is_transmitting}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_count", {27'd0, tx_count}, 32'd0);
    check("rst_mid_transmit", {31'd0, uart_transmit}, 32'd0);
    check("rst_mid_tx_byte", {24'd0, uart_tx_byte}, 32'h00);
    check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    exp_tx.delete();
    pulses_before = pulse_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_pulse_after_reset", pulse_cnt, pulses_before);
    check("tx_count_after_reset", {27'd0, tx_count}, 32'd0);
    abandon = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
